mem_wb_stage: RTL and testbench

Writeback pipeline stage that sits directly downstream of the data-memory stage. It registers the memory-stage results: ALU result, load data, destination register and control bits. It aligns and extends load data, then selects the writeback value. It drives the register-file write port and the writeback forwarding path. It supports stall and flush and keeps a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 116 +++++++++++
 tb/tb_mem_wb_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-to-writeback pipeline register with load alignment,
// writeback mux, register-file write port drive and retired-instruction count.
// Optional feature macro: MEM_WB_SUBWORD_LOAD_EN enables byte/halfword
// extraction with sign/zero extension; without it every load returns the
// memory word unmodified and the size/signedness inputs are not registered.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_w,
  input  logic        flush_w,
  input  logic        valid_m,
  input  logic        reg_write_m,
  input  logic        mem_to_reg_m,
  input  logic [1:0]  load_size_m,
  input  logic        load_unsigned_m,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] read_data_m,
  input  logic [4:0]  write_reg_m,
  output logic        valid_w,
  output logic        reg_write_w,
  output logic [4:0]  write_reg_w,
  output logic [31:0] result_w,
  output logic [31:0] retired_count
);

  logic        valid_q;
  logic        reg_write_q;
  logic        mem_to_reg_q;
  logic [31:0] alu_out_q;
  logic [31:0] read_data_q;
  logic [4:0]  write_reg_q;
  logic [31:0] count_q;
  logic [31:0] load_ext;

`ifdef MEM_WB_SUBWORD_LOAD_EN
  logic [1:0]  load_size_q;
  logic        load_unsigned_q;

  // Sub-word load attributes: reset/flush clear, stall holds, otherwise capture
  always_ff @(posedge clk) begin
    if (!rst_n || flush_w) begin
      load_size_q     <= '0;
      load_unsigned_q <= 1'b0;
    end else if (!stall_w) begin
      load_size_q     <= load_size_m;
      load_unsigned_q <= load_unsigned_m;
    end
  end

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Little-endian lane selection from the registered address, then extension
  always_comb begin
    byte_lane = read_data_q[7:0];
    case (alu_out_q[1:0])
      2'b00:   byte_lane = read_data_q[7:0];
      2'b01:   byte_lane = read_data_q[15:8];
      2'b10:   byte_lane = read_data_q[23:16];
      default: byte_lane = read_data_q[31:24];
    endcase
    half_lane = alu_out_q[1] ? read_data_q[31:16] : read_data_q[15:0];
    case (load_size_q)
      2'b10:   load_ext = load_unsigned_q ? {24'h0, byte_lane}
                                          : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = load_unsigned_q ? {16'h0, half_lane}
                                          : {{16{half_lane[15]}}, half_lane};
      default: load_ext = read_data_q;
    endcase
  end
`else
  // Size/signedness inputs have no effect in the word-only build
  logic unused_load_attr;
  assign unused_load_attr = ^{load_size_m, load_unsigned_m};

  // Word-only build: loads pass the memory word straight through
  always_comb begin
    load_ext = read_data_q;
  end
`endif

  // W register: reset, then flush (bubble), then stall (hold), then capture
  always_ff @(posedge clk) begin
    if (!rst_n || flush_w) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_out_q    <= '0;
      read_data_q  <= '0;
      write_reg_q  <= '0;
    end else if (!stall_w) begin
      valid_q      <= valid_m;
      reg_write_q  <= reg_write_m;
      mem_to_reg_q <= mem_to_reg_m;
      alu_out_q    <= alu_out_m;
      read_data_q  <= read_data_m;
      write_reg_q  <= write_reg_m;
    end
  end

  // Retire counter: a valid instruction leaving W (flush included) counts once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (valid_q && !stall_w) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign valid_w       = valid_q;
  assign write_reg_w   = write_reg_q;
  assign reg_write_w   = valid_q & reg_write_q & (write_reg_q != 5'd0);
  assign result_w      = mem_to_reg_q ? load_ext : alu_out_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed steps with a scoreboard of expected
// W-stage outputs pushed at drive time and popped after the capturing edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall_w, flush_w, valid_m, reg_write_m, mem_to_reg_m;
  logic [1:0]  load_size_m;
  logic        load_unsigned_m;
  logic [31:0] alu_out_m, read_data_m;
  logic [4:0]  write_reg_m;
  logic        valid_w, reg_write_w;
  logic [4:0]  write_reg_w;
  logic [31:0] result_w, retired_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] res;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  // Reference model state of the W register
  logic        m_valid, m_rw, m_m2r, m_uns;
  logic [1:0]  m_size;
  logic [31:0] m_alu, m_rd, m_cnt;
  logic [4:0]  m_wr;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .load_size_m(load_size_m), .load_unsigned_m(load_unsigned_m),
    .alu_out_m(alu_out_m), .read_data_m(read_data_m), .write_reg_m(write_reg_m),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
    .result_w(result_w), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_result();
    logic [31:0] sh;
    if (!m_m2r) return m_alu;
`ifdef MEM_WB_SUBWORD_LOAD_EN
    if (m_size == 2'b10) begin
      sh = m_rd >> (8 * m_alu[1:0]);
      return m_uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    end
    if (m_size == 2'b01) begin
      sh = m_rd >> (16 * m_alu[1]);
      return m_uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    end
`endif
    return m_rd;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance the model for the inputs now applied, queue the expectation,
  // clock the DUT and compare against the popped expectation.
  task automatic tick(input string tag);
    exp_t e;
    if (!rst_n) begin
      {m_valid, m_rw, m_m2r, m_uns, m_size, m_alu, m_rd, m_wr, m_cnt} = '0;
    end else begin
      if (m_valid && !stall_w) m_cnt = m_cnt + 32'd1;
      if (flush_w) begin
        {m_valid, m_rw, m_m2r, m_uns, m_size, m_alu, m_rd, m_wr} = '0;
      end else if (!stall_w) begin
        m_valid = valid_m; m_rw = reg_write_m; m_m2r = mem_to_reg_m;
        m_uns = load_unsigned_m; m_size = load_size_m;
        m_alu = alu_out_m; m_rd = read_data_m; m_wr = write_reg_m;
      end
    end
    e.valid = m_valid;
    e.rw    = m_valid & m_rw & (m_wr != 5'd0);
    e.wr    = m_wr;
    e.res   = model_result();
    e.cnt   = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, ".valid_w"},       {31'h0, valid_w},     {31'h0, e.valid});
    check({tag, ".reg_write_w"},   {31'h0, reg_write_w}, {31'h0, e.rw});
    check({tag, ".write_reg_w"},   {27'h0, write_reg_w}, {27'h0, e.wr});
    check({tag, ".result_w"},      result_w,             e.res);
    check({tag, ".retired_count"}, retired_count,        e.cnt);
  endtask

  task automatic drive(input string tag, input logic rst, input logic stall,
                       input logic flush, input logic v, input logic rw,
                       input logic m2r, input logic [1:0] size, input logic uns,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input logic [4:0] wr);
    @(negedge clk);
    rst_n = rst; stall_w = stall; flush_w = flush; valid_m = v;
    reg_write_m = rw; mem_to_reg_m = m2r; load_size_m = size;
    load_unsigned_m = uns; alu_out_m = alu; read_data_m = rd; write_reg_m = wr;
    tick(tag);
  endtask

  initial begin
    {m_valid, m_rw, m_m2r, m_uns, m_size, m_alu, m_rd, m_wr, m_cnt} = '0;

    // Reset held with active inputs
    drive("rst0", 0, 0, 0, 1, 1, 1, 2'b10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    drive("rst1", 0, 0, 0, 1, 1, 0, 2'b00, 0, 32'h1111_1111, 32'h2222_2222, 5'd9);
    check("rst_result_zero", result_w, 32'h0);

    // First ALU op after reset release
    drive("alu", 1, 0, 0, 1, 1, 0, 2'b00, 0, 32'h0000_1234, 32'h0, 5'd5);
    check("alu_result_direct", result_w, 32'h0000_1234);

    // Byte loads, signed and unsigned, lane 3
    drive("lb3s", 1, 0, 0, 1, 1, 1, 2'b10, 0, 32'h1000_0003, 32'h80FF_7F01, 5'd6);
`ifdef MEM_WB_SUBWORD_LOAD_EN
    check("lb_signed_direct", result_w, 32'hFFFF_FF80);
`else
    check("lb_signed_direct", result_w, 32'h80FF_7F01);
`endif
    drive("lb3u", 1, 0, 0, 1, 1, 1, 2'b10, 1, 32'h1000_0003, 32'h80FF_7F01, 5'd6);
`ifdef MEM_WB_SUBWORD_LOAD_EN
    check("lb_unsigned_direct", result_w, 32'h0000_0080);
`else
    check("lb_unsigned_direct", result_w, 32'h80FF_7F01);
`endif
    drive("lb0s", 1, 0, 0, 1, 1, 1, 2'b10, 0, 32'h1000_0000, 32'h80FF_7F01, 5'd7);
    drive("lb1s", 1, 0, 0, 1, 1, 1, 2'b10, 0, 32'h1000_0001, 32'h80FF_7F01, 5'd7);
    drive("lb2s", 1, 0, 0, 1, 1, 1, 2'b10, 0, 32'h1000_0002, 32'h80FF_7F01, 5'd7);

    // Halfword loads; addr[0] must be ignored
    drive("lh2s", 1, 0, 0, 1, 1, 1, 2'b01, 0, 32'h2000_0002, 32'h8001_1234, 5'd8);
`ifdef MEM_WB_SUBWORD_LOAD_EN
    check("lh_signed_direct", result_w, 32'hFFFF_8001);
`else
    check("lh_signed_direct", result_w, 32'h8001_1234);
`endif
    drive("lh1u", 1, 0, 0, 1, 1, 1, 2'b01, 1, 32'h2000_0001, 32'h8001_F234, 5'd8);
    drive("lh0s", 1, 0, 0, 1, 1, 1, 2'b01, 0, 32'h2000_0000, 32'h8001_F234, 5'd8);
    drive("lh3s", 1, 0, 0, 1, 1, 1, 2'b01, 0, 32'h2000_0003, 32'h8001_F234, 5'd8);
    drive("lw11", 1, 0, 0, 1, 1, 1, 2'b11, 0, 32'h2000_0001, 32'hCAFE_BABE, 5'd9);

    // Register zero: no write, still retires
    drive("r0",   1, 0, 0, 1, 1, 0, 2'b00, 0, 32'h0000_00AA, 32'h0, 5'd0);
    check("r0_no_write", {31'h0, reg_write_w}, 32'h0);
    drive("nop",  1, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);

    // Capture, stall three cycles with changing inputs, then flush+stall
    drive("cap",  1, 0, 0, 1, 1, 0, 2'b00, 0, 32'h0000_ABCD, 32'h0, 5'd7);
    drive("st1",  1, 1, 0, 1, 1, 1, 2'b10, 0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3);
    drive("st2",  1, 1, 0, 1, 0, 0, 2'b00, 1, 32'h5555_5555, 32'h0, 5'd4);
    drive("st3",  1, 1, 0, 0, 1, 1, 2'b01, 0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 5'd1);
    check("stall_hold_direct", result_w, 32'h0000_ABCD);
    drive("fst",  1, 1, 1, 1, 1, 0, 2'b00, 0, 32'h7777_7777, 32'h0, 5'd2);
    check("flush_stall_bubble", {31'h0, valid_w}, 32'h0);

    // Flush alone still counts the departing instruction
    drive("cap2", 1, 0, 0, 1, 1, 0, 2'b00, 0, 32'h0000_0042, 32'h0, 5'd10);
    drive("fl",   1, 0, 1, 1, 1, 0, 2'b00, 0, 32'h0000_0099, 32'h0, 5'd11);
    drive("aft",  1, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);

    // Reset in mid-stall discards the held instruction
    drive("cap3", 1, 0, 0, 1, 1, 0, 2'b00, 0, 32'h0000_0777, 32'h0, 5'd12);
    drive("st4",  1, 1, 0, 1, 1, 0, 2'b00, 0, 32'h0000_0888, 32'h0, 5'd13);
    drive("rstst",0, 1, 0, 1, 1, 0, 2'b00, 0, 32'h0000_0999, 32'h0, 5'd14);
    drive("idle", 1, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);

    // Counter wrap: preload all-ones, then retire one instruction
    drive("w0",   1, 0, 0, 1, 1, 0, 2'b00, 0, 32'h0000_0001, 32'h0, 5'd15);
    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    m_cnt = 32'hFFFF_FFFF;
    rst_n = 1; stall_w = 0; flush_w = 0; valid_m = 0; reg_write_m = 0;
    mem_to_reg_m = 0; alu_out_m = '0; read_data_m = '0; write_reg_m = '0;
    tick("wrap");
    check("wrap_direct", retired_count, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
